// File: rtl/imem_fetch_sequencer_if.sv
// rtl/imem_fetch_sequencer_if.sv - memory, decode and debug bus of the fetch sequencer
//
// Signals:
//   imem_addr/imem_data       combinational instruction memory port (8-bit address, 16-bit word)
//   instr_valid/instr_ready   output register handshake toward decode
//   instr/instr_pc            delivered instruction and its address
//   dbg_req/dbg_addr          debug read request (held until dbg_ack)
//   dbg_ack/dbg_rdata         one-cycle debug completion with registered read data
// Modports: master = sequencer, slave = memory/decode/debug side.
interface imem_fetch_sequencer_if;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        dbg_req;
    logic [7:0]  dbg_addr;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        input  dbg_req,
        input  dbg_addr,
        output dbg_ack,
        output dbg_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        output dbg_req,
        output dbg_addr,
        input  dbg_ack,
        input  dbg_rdata
    );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// rtl/imem_fetch_sequencer.sv - instruction fetch sequencer with redirect, halt and debug port sharing
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start, stop           control pulses (stop has priority)
//   redirect_valid/pc     load a new PC (flushes the output register while running)
//   halted, halt_pc       halt status and address of the halting word
//   bus                   memory, decode handshake and debug read signals (master modport)
module imem_fetch_sequencer #(
    parameter logic [7:0]  RESET_PC     = 8'h00,
    parameter logic [15:0] HALT_WORD    = 16'h0000,
    parameter bit          HALT_EN      = 1'b1,
    parameter int          DBG_MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_pc,
    output logic       halted,
    output logic [7:0] halt_pc,
    imem_fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT = 4'(DBG_MAX_WAIT);

    state_t     state;
    logic [7:0] pc;
    logic [3:0] wait_cnt;

    logic run;
    logic xfer;
    logic fetch_ok;
    logic dbg_gnt;
    logic fetch_go;
    logic halt_hit;

    always_comb begin
        run      = (state == ST_RUN);
        xfer     = bus.instr_valid && bus.instr_ready;
        fetch_ok = run && !redirect_valid && !stop && (!bus.instr_valid || bus.instr_ready);
        // Debug wins the port whenever fetch has nothing to do, otherwise only
        // after it has waited DBG_MAX_WAIT cycles. Never grant in an ack cycle
        // so a request still held high is not served twice.
        dbg_gnt  = bus.dbg_req && !bus.dbg_ack && (!fetch_ok || wait_cnt == MAX_WAIT);
        fetch_go = fetch_ok && !dbg_gnt;
        halt_hit = fetch_go && HALT_EN && (bus.imem_data == HALT_WORD);
    end

    assign bus.imem_addr = dbg_gnt ? bus.dbg_addr : pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            pc              <= RESET_PC;
            wait_cnt        <= 4'd0;
            halted          <= 1'b0;
            halt_pc         <= 8'h00;
            bus.instr_valid <= 1'b0;
            bus.instr       <= 16'h0000;
            bus.instr_pc    <= 8'h00;
            bus.dbg_ack     <= 1'b0;
            bus.dbg_rdata   <= 16'h0000;
        end else begin
            bus.dbg_ack <= dbg_gnt;
            if (dbg_gnt) begin
                bus.dbg_rdata <= bus.imem_data;
            end

            if (dbg_gnt) begin
                wait_cnt <= 4'd0;
            end else if (bus.dbg_req && !bus.dbg_ack && wait_cnt != MAX_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (stop) begin
                state           <= ST_IDLE;
                halted          <= 1'b0;
                bus.instr_valid <= 1'b0;
                if (redirect_valid) begin
                    pc <= redirect_pc;
                end
            end else if (start && !run) begin
                // start beats a simultaneous redirect
                state           <= ST_RUN;
                halted          <= 1'b0;
                pc              <= RESET_PC;
                bus.instr_valid <= 1'b0;
            end else if (redirect_valid) begin
                pc <= redirect_pc;
                if (run || xfer) begin
                    bus.instr_valid <= 1'b0;
                end
            end else if (halt_hit) begin
                // The halt word itself is never loaded; whatever already sits
                // in the output register is still delivered normally.
                state   <= ST_HALTED;
                halted  <= 1'b1;
                halt_pc <= pc;
                if (xfer) begin
                    bus.instr_valid <= 1'b0;
                end
            end else if (fetch_go) begin
                bus.instr       <= bus.imem_data;
                bus.instr_pc    <= pc;
                bus.instr_valid <= 1'b1;
                pc              <= pc + 8'd1;
            end else if (xfer) begin
                bus.instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb/tb_imem_fetch_sequencer.sv - directed self-checking bench for imem_fetch_sequencer
module tb_imem_fetch_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start_a, stop_a, redir_a;
    logic [7:0] rpc_a;
    logic       halted_a;
    logic [7:0] halt_pc_a;
    logic       start_b, stop_b, redir_b;
    logic [7:0] rpc_b;
    logic       halted_b;
    logic [7:0] halt_pc_b;

    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    int errors = 0;
    int checks = 0;

    imem_fetch_sequencer_if ifa ();
    imem_fetch_sequencer_if ifb ();

    assign ifa.imem_data = mem_a[ifa.imem_addr];
    assign ifb.imem_data = mem_b[ifb.imem_addr];

    imem_fetch_sequencer #(.HALT_EN(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop_a),
        .redirect_valid(redir_a), .redirect_pc(rpc_a),
        .halted(halted_a), .halt_pc(halt_pc_a), .bus(ifa)
    );

    imem_fetch_sequencer #(.HALT_EN(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b),
        .redirect_valid(redir_b), .redirect_pc(rpc_b),
        .halted(halted_b), .halt_pc(halt_pc_b), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_instr(input string tag, input logic [15:0] w, input logic [7:0] a);
        chk({tag, ".valid"}, {15'd0, ifa.instr_valid}, 16'd1);
        chk({tag, ".instr"}, ifa.instr, w);
        chk({tag, ".pc"}, {8'd0, ifa.instr_pc}, {8'd0, a});
    endtask

    task automatic chk_instr_b(input string tag, input logic [15:0] w, input logic [7:0] a);
        chk({tag, ".valid"}, {15'd0, ifb.instr_valid}, 16'd1);
        chk({tag, ".instr"}, ifb.instr, w);
        chk({tag, ".pc"}, {8'd0, ifb.instr_pc}, {8'd0, a});
    endtask

    logic [15:0] prog [9];

    initial begin
        prog = '{16'h485A, 16'h4A14, 16'h4DF6, 16'h4F96, 16'h0880,
                 16'h4E02, 16'h6180, 16'h6800, 16'h8820};
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        for (int i = 0; i < 9; i++) mem_a[i] = prog[i];
        mem_b[8'h00] = 16'h485A;
        mem_b[8'h03] = 16'h4A14;
        mem_b[8'hFF] = 16'h1234;

        reset_n = 1'b0;
        start_a = 0; stop_a = 0; redir_a = 0; rpc_a = 8'h00;
        start_b = 0; stop_b = 0; redir_b = 0; rpc_b = 8'h00;
        ifa.instr_ready = 0; ifa.dbg_req = 0; ifa.dbg_addr = 8'h00;
        ifb.instr_ready = 0; ifb.dbg_req = 0; ifb.dbg_addr = 8'h00;
        tick();
        tick();

        // reset state
        chk("rst.valid", {15'd0, ifa.instr_valid}, 16'd0);
        chk("rst.instr", ifa.instr, 16'h0000);
        chk("rst.instr_pc", {8'd0, ifa.instr_pc}, 16'h0000);
        chk("rst.halted", {15'd0, halted_a}, 16'd0);
        chk("rst.halt_pc", {8'd0, halt_pc_a}, 16'h0000);
        chk("rst.dbg_ack", {15'd0, ifa.dbg_ack}, 16'd0);
        chk("rst.dbg_rdata", ifa.dbg_rdata, 16'h0000);
        chk("rst.imem_addr", {8'd0, ifa.imem_addr}, 16'h0000);
        reset_n = 1'b1;
        tick();

        // straight-line program up to the halt word at 09
        start_a = 1; ifa.instr_ready = 1;
        tick();
        start_a = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_instr("seq", prog[i], 8'(i));
        end
        tick();
        chk("halt.valid", {15'd0, ifa.instr_valid}, 16'd0);
        chk("halt.halted", {15'd0, halted_a}, 16'd1);
        chk("halt.halt_pc", {8'd0, halt_pc_a}, 16'h0009);
        tick();
        chk("halt.valid2", {15'd0, ifa.instr_valid}, 16'd0);
        chk("halt.pc_hold", {8'd0, ifa.imem_addr}, 16'h0009);

        // back-pressure
        start_a = 1;
        tick();
        start_a = 0;
        chk("bp.unhalt", {15'd0, halted_a}, 16'd0);
        tick();
        tick();
        tick();
        chk_instr("bp.pre", 16'h4DF6, 8'h02);
        ifa.instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_instr("bp.hold", 16'h4DF6, 8'h02);
            chk("bp.pc", {8'd0, ifa.imem_addr}, 16'h0003);
        end
        ifa.instr_ready = 1;
        tick();
        chk_instr("bp.rel1", 16'h4F96, 8'h03);
        tick();
        chk_instr("bp.rel2", 16'h0880, 8'h04);

        // redirect while 4A14@01 waits unaccepted
        stop_a = 1;
        tick();
        stop_a = 0;
        chk("stop.valid", {15'd0, ifa.instr_valid}, 16'd0);
        start_a = 1;
        tick();
        start_a = 0;
        tick();
        tick();
        chk_instr("rd.pend", 16'h4A14, 8'h01);
        ifa.instr_ready = 0; redir_a = 1; rpc_a = 8'h06;
        tick();
        redir_a = 0; ifa.instr_ready = 1;
        chk("rd.flush", {15'd0, ifa.instr_valid}, 16'd0);
        tick();
        chk_instr("rd.first", 16'h6180, 8'h06);
        tick();
        chk_instr("rd.second", 16'h6800, 8'h07);
        stop_a = 1;
        tick();
        stop_a = 0;

        // debug read under bounded-wait arbitration
        start_a = 1;
        tick();
        start_a = 0;
        tick();
        chk_instr("dbg.c0", 16'h485A, 8'h00);
        ifa.dbg_req = 1; ifa.dbg_addr = 8'h04;
        tick();
        chk("dbg.ack1", {15'd0, ifa.dbg_ack}, 16'd0);
        chk_instr("dbg.c1", 16'h4A14, 8'h01);
        tick();
        chk_instr("dbg.c2", 16'h4DF6, 8'h02);
        tick();
        chk_instr("dbg.c3", 16'h4F96, 8'h03);
        tick();
        chk_instr("dbg.c4", 16'h0880, 8'h04);
        chk("dbg.ack4", {15'd0, ifa.dbg_ack}, 16'd0);
        chk("dbg.gnt_addr", {8'd0, ifa.imem_addr}, 16'h0004);
        tick();
        chk("dbg.ack", {15'd0, ifa.dbg_ack}, 16'd1);
        chk("dbg.rdata", ifa.dbg_rdata, 16'h0880);
        chk("dbg.bubble", {15'd0, ifa.instr_valid}, 16'd0);
        chk("dbg.no_regrant", {8'd0, ifa.imem_addr}, 16'h0005);
        tick();
        chk("dbg.ack_once", {15'd0, ifa.dbg_ack}, 16'd0);
        chk_instr("dbg.after", 16'h4E02, 8'h05);
        ifa.dbg_req = 0;
        tick();
        chk("dbg.ack_off", {15'd0, ifa.dbg_ack}, 16'd0);
        chk_instr("dbg.after2", 16'h6180, 8'h06);
        stop_a = 1;
        tick();
        stop_a = 0;

        // HALT_EN=0 instance: start beats redirect, then wrap FF -> 00
        start_b = 1; redir_b = 1; rpc_b = 8'hFF; ifb.instr_ready = 1;
        tick();
        start_b = 0; redir_b = 0;
        tick();
        chk_instr_b("wr.start", 16'h485A, 8'h00);
        redir_b = 1; rpc_b = 8'hFF;
        tick();
        redir_b = 0;
        chk("wr.flush", {15'd0, ifb.instr_valid}, 16'd0);
        tick();
        chk_instr_b("wr.ff", 16'h1234, 8'hFF);
        tick();
        chk_instr_b("wr.00", 16'h485A, 8'h00);
        tick();
        chk_instr_b("wr.zero1", 16'h0000, 8'h01);
        tick();
        chk_instr_b("wr.zero2", 16'h0000, 8'h02);
        tick();
        chk_instr_b("wr.03", 16'h4A14, 8'h03);
        chk("wr.halted", {15'd0, halted_b}, 16'd0);

        // asynchronous reset mid-run with a debug request pending
        start_a = 1;
        tick();
        start_a = 0;
        tick();
        ifa.dbg_req = 1; ifa.dbg_addr = 8'h02;
        tick();
        chk_instr("ar.pre", 16'h4A14, 8'h01);
        reset_n = 1'b0;
        #1;
        chk("ar.valid", {15'd0, ifa.instr_valid}, 16'd0);
        chk("ar.instr", ifa.instr, 16'h0000);
        chk("ar.instr_pc", {8'd0, ifa.instr_pc}, 16'h0000);
        chk("ar.ack", {15'd0, ifa.dbg_ack}, 16'd0);
        chk("ar.rdata", ifa.dbg_rdata, 16'h0000);
        chk("ar.halted", {15'd0, halted_a}, 16'd0);
        chk("ar.b_valid", {15'd0, ifb.instr_valid}, 16'd0);
        tick();
        tick();
        chk("ar.ack_hold", {15'd0, ifa.dbg_ack}, 16'd0);
        ifa.dbg_req = 0;
        reset_n = 1'b1;
        #1;
        chk("ar.pc", {8'd0, ifa.imem_addr}, 16'h0000);
        tick();
        chk("ar.ack_post", {15'd0, ifa.dbg_ack}, 16'd0);
        chk("ar.valid_post", {15'd0, ifa.instr_valid}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
